// File: rtl/selen_wb_arb_pkg.sv
// Shared types and defaults for the two-master Wishbone arbiter.
package selen_wb_arb_pkg;
  localparam int unsigned ARB_AW      = 32;
  localparam int unsigned ARB_DW      = 32;
  localparam int unsigned ARB_TIMEOUT = 64;

  typedef enum logic [1:0] {ARB_IDLE, ARB_GNT0, ARB_GNT1, ARB_ABORT} arb_state_t;
  typedef logic arb_idx_t;
endpackage

// File: rtl/selen_wb_arb_wdt.sv
// Per-transfer watchdog: counts stalled strobe cycles and flags the last allowed one.
module selen_wb_arb_wdt
  import selen_wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] wdt_q, wdt_d;

  always_comb begin
    wdt_d = wdt_q;
    if (clr_i) wdt_d = '0;
    else if (en_i && (wdt_q != {CW{1'b1}})) wdt_d = wdt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) wdt_q <= '0;
    else     wdt_q <= wdt_d;
  end

  // en_i already excludes a response, so a same-cycle ack always beats expiry.
  assign expire_o = (TIMEOUT != 0) && en_i && !clr_i && (wdt_q == LAST);
endmodule

// File: rtl/selen_wb_arbiter.sv
// Round-robin Wishbone classic arbiter for L1I (m0) and L1D (m1) refill ports,
// grant locked for the whole cyc of the winner, with a stalled-access watchdog.
module selen_wb_arbiter
  import selen_wb_arb_pkg::*;
#(
  parameter int unsigned AW      = ARB_AW,
  parameter int unsigned DW      = ARB_DW,
  parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i
);
  arb_state_t state_q, state_d;
  arb_idx_t   gnt_q, gnt_d, prio_q, prio_d;

  logic            granted, resp, wdt_expire;
  logic            cur_cyc, cur_stb, cur_we;
  logic [AW-1:0]   cur_adr;
  logic [DW-1:0]   cur_dat, r_dat;
  logic [DW/8-1:0] cur_sel;
  logic            r_ack, r_err;

  assign granted = (state_q == ARB_GNT0) || (state_q == ARB_GNT1);
  assign resp    = s_ack_i | s_err_i;
  assign cur_cyc = gnt_q ? m1_cyc_i : m0_cyc_i;
  assign cur_stb = gnt_q ? m1_stb_i : m0_stb_i;
  assign cur_we  = gnt_q ? m1_we_i  : m0_we_i;
  assign cur_adr = gnt_q ? m1_adr_i : m0_adr_i;
  assign cur_dat = gnt_q ? m1_dat_i : m0_dat_i;
  assign cur_sel = gnt_q ? m1_sel_i : m0_sel_i;

  // Holding the counter clear outside a grant gives the clear-on-entry behaviour.
  selen_wb_arb_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!granted || resp),
    .en_i     (granted && cur_stb && !resp),
    .expire_o (wdt_expire)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    prio_d  = prio_q;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    r_dat   = '0;
    r_ack   = 1'b0;
    r_err   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (m0_cyc_i || m1_cyc_i) begin
          gnt_d   = (m0_cyc_i && m1_cyc_i) ? prio_q : m1_cyc_i;
          state_d = gnt_d ? ARB_GNT1 : ARB_GNT0;
        end
      end
      ARB_GNT0, ARB_GNT1: begin
        s_cyc_o = cur_cyc;
        s_stb_o = cur_stb;
        s_we_o  = cur_we;
        s_adr_o = cur_adr;
        s_dat_o = cur_dat;
        s_sel_o = cur_sel;
        r_dat   = s_dat_i;
        r_ack   = s_ack_i;
        r_err   = s_err_i | wdt_expire;
        if (!cur_cyc) begin
          state_d = ARB_IDLE;
          prio_d  = ~gnt_q;
        end else if (wdt_expire) begin
          state_d = ARB_ABORT;
        end
      end
      ARB_ABORT: begin
        if (!cur_cyc) begin
          state_d = ARB_IDLE;
          prio_d  = ~gnt_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign m0_ack_o = r_ack & ~gnt_q;
  assign m0_err_o = r_err & ~gnt_q;
  assign m0_dat_o = gnt_q ? '0 : r_dat;
  assign m1_ack_o = r_ack & gnt_q;
  assign m1_err_o = r_err & gnt_q;
  assign m1_dat_o = gnt_q ? r_dat : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      prio_q  <= prio_d;
    end
  end
endmodule

// File: tb/tb_selen_wb_arbiter.sv
// Directed bench for selen_wb_arbiter with TIMEOUT=8 and a hand-driven slave.
module tb_selen_wb_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m0_adr, m1_adr, s_adr_o;
  logic [DW-1:0] m0_wdat, m1_wdat, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic [SW-1:0] m0_sel, m1_sel, s_sel_o;
  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_GNT0 = 2'd1, ST_GNT1 = 2'd2, ST_ABORT = 2'd3;

  always #5 clk = ~clk;

  selen_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_wdat), .m0_sel_i(m0_sel), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_wdat), .m1_sel_i(m1_sel), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = '0;
    m0_adr = '0; m1_adr = '0; m0_wdat = '0; m1_wdat = '0;
    m0_sel = '1; m1_sel = '1;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
    step(); step();
    rst = 1'b0; #1;
    check("rst_state", dut.state_q, ST_IDLE);
    check("rst_prio", dut.prio_q, 0);
    check("rst_scyc", s_cyc_o, 0);
    check("rst_sstb", s_stb_o, 0);
    check("rst_m0ack", m0_ack_o, 0);
    check("rst_m1err", m1_err_o, 0);

    // Single master read with ack in the 3rd granted cycle
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10; #1;
    check("t1_lat0", s_cyc_o, 0);
    step(); #1;
    check("t1_scyc", s_cyc_o, 1);
    check("t1_sadr", s_adr_o, 32'h10);
    check("t1_noack1", m0_ack_o, 0);
    step(); #1;
    check("t1_noack2", m0_ack_o, 0);
    step(); s_ack_i = 1; s_dat_i = 32'hDEADBEEF; #1;
    check("t1_ack", m0_ack_o, 1);
    check("t1_dat", m0_dat_o, 32'hDEADBEEF);
    check("t1_m1ack", m1_ack_o, 0);
    check("t1_m1dat", m1_dat_o, 0);
    step(); s_ack_i = 0; m0_cyc = 0; m0_stb = 0; #1;
    step(); #1;
    check("t1_idle", dut.state_q, ST_IDLE);
    check("t1_prio", dut.prio_q, 1);

    // Tie after reset: m0 first, bubble, then repeat tie goes to m1
    rst = 1; step(); rst = 0; #1;
    check("t2_rstprio", dut.prio_q, 0);
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200;
    step(); #1;
    check("t2_gnt0", dut.state_q, ST_GNT0);
    check("t2_sadr0", s_adr_o, 32'h100);
    s_ack_i = 1; s_dat_i = 32'h1111; #1;
    check("t2_m0ack", m0_ack_o, 1);
    check("t2_m1ack", m1_ack_o, 0);
    step(); s_ack_i = 0; m0_cyc = 0; m0_stb = 0; #1;
    step(); #1;
    check("t2_bubble", dut.state_q, ST_IDLE);
    check("t2_bubcyc", s_cyc_o, 0);
    m0_cyc = 1; m0_stb = 1;
    step(); #1;
    check("t2_gnt1", dut.state_q, ST_GNT1);
    check("t2_sadr1", s_adr_o, 32'h200);

    // Locked 4-beat burst on m1 while m0 waits
    for (int i = 0; i < 4; i++) begin
      m1_adr = 32'h200 + 32'(4 * i); s_ack_i = 1; s_dat_i = 32'hA0 + 32'(i); #1;
      check("t3_m1ack", m1_ack_o, 1);
      check("t3_m1dat", m1_dat_o, 32'hA0 + 32'(i));
      check("t3_m0ack", m0_ack_o, 0);
      check("t3_sadr", s_adr_o, 32'h200 + 32'(4 * i));
      step();
    end
    s_ack_i = 0; m1_cyc = 0; m1_stb = 0; #1;
    check("t3_held", dut.state_q, ST_GNT1);
    step(); #1;
    check("t3_bubble", s_cyc_o, 0);
    step(); #1;
    check("t3_gnt0", dut.state_q, ST_GNT0);
    check("t3_sadr0", s_adr_o, 32'h100);
    m0_cyc = 0; m0_stb = 0;
    step(); #1;

    // Timeout: err in the 8th stalled cycle, then ABORT until cyc drops
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h300;
    step();
    for (int i = 1; i <= 8; i++) begin
      #1;
      check("t4_err", m0_err_o, (i == 8));
      if (i < 8) step();
    end
    check("t4_noack", m0_ack_o, 0);
    step(); s_ack_i = 1; #1;
    check("t4_abort", dut.state_q, ST_ABORT);
    check("t4_scyc", s_cyc_o, 0);
    check("t4_drop", m0_ack_o, 0);
    s_ack_i = 0;
    step(); #1;
    check("t4_stay", dut.state_q, ST_ABORT);
    m0_cyc = 0; m0_stb = 0;
    step(); #1;
    check("t4_idle", dut.state_q, ST_IDLE);

    // Ack coinciding with expiry wins and restarts the count
    m0_cyc = 1; m0_stb = 1;
    step();
    for (int i = 1; i <= 8; i++) begin
      #1;
      if (i == 8) begin
        s_ack_i = 1; s_dat_i = 32'hCAFE; #1;
        check("t5_ack", m0_ack_o, 1);
        check("t5_noerr", m0_err_o, 0);
      end else begin
        check("t5_stall", m0_err_o, 0);
        step();
      end
    end
    step(); s_ack_i = 0; #1;
    check("t5_cont", dut.state_q, ST_GNT0);
    check("t5_scyc", s_cyc_o, 1);
    for (int i = 1; i < 8; i++) begin
      check("t5_restall", m0_err_o, 0);
      step(); #1;
    end
    check("t5_err8", m0_err_o, 1);
    step(); #1;
    m0_cyc = 0; m0_stb = 0;
    step(); #1;

    // Reset mid-burst in GNT1
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h400;
    step(); s_ack_i = 1; s_dat_i = 32'h5555; #1;
    check("t6_gnt1", dut.state_q, ST_GNT1);
    check("t6_m1ack", m1_ack_o, 1);
    rst = 1; m0_cyc = 1; m0_stb = 1; m0_adr = 32'h500;
    step(); rst = 0; s_dat_i = 32'hFFFF; #1;
    check("t6_state", dut.state_q, ST_IDLE);
    check("t6_prio", dut.prio_q, 0);
    check("t6_scyc", s_cyc_o, 0);
    check("t6_sstb", s_stb_o, 0);
    check("t6_m1ack", m1_ack_o, 0);
    check("t6_m1dat", m1_dat_o, 0);
    check("t6_m0ack", m0_ack_o, 0);
    step(); s_ack_i = 0; #1;
    check("t6_tie0", dut.state_q, ST_GNT0);
    check("t6_sadr", s_adr_o, 32'h500);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
